ram_arbiter: RTL and testbench

- Arbitrates the single RAM port between the coherent data bus controller and the instruction fetch requests of both cores.
- Sits directly downstream of the data bus controller: consumes its dramREN/dramWEN/dramaddr/dramstore and returns ramwait/dramload.
- Instruction side serves CPUS icaches one word per grant, round-robin between cores.
- Data has priority, with a fairness token that prevents instruction starvation.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types.
//   word_t      : 32-bit machine word
//   ramstate_t  : state reported by the RAM (FREE, BUSY, ACCESS, ERROR)
//   arb_state_t : ram_arbiter grant state (IDLE, DATA, INST)
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } arb_state_t;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single RAM port between the coherent data bus
// controller and the per-core instruction fetch ports.
//
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   dramREN/dramWEN           data bus read/write request
//   dramaddr/dramstore        data bus word address / write data
//   dramload, ramwait         data bus read data / wait (0 on completed word)
//   iREN[CPUS]                per-core instruction read request
//   iaddr[CPUS]               per-core instruction address
//   iwait[CPUS], iload[CPUS]  per-core wait (0 on completed word) / data
//   ramREN/ramWEN             RAM read/write enable
//   ramaddr/ramstore          RAM address / write data
//   ramload, ramstate         RAM read data / RAM status
//
// The grant is registered; RAM-side outputs are combinational from the
// current grant so the granted source's address/data pass straight through.
// The round-robin pointer is one bit, so CPUS must be 2.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      dramREN,
  input  logic                      dramWEN,
  input  logic [31:0]               dramaddr,
  input  logic [31:0]               dramstore,
  output logic [31:0]               dramload,
  output logic                      ramwait,
  input  logic [CPUS-1:0]           iREN,
  input  logic [CPUS-1:0][31:0]     iaddr,
  output logic [CPUS-1:0]           iwait,
  output logic [CPUS-1:0][31:0]     iload,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [31:0]               ramaddr,
  output logic [31:0]               ramstore,
  input  logic [31:0]               ramload,
  input  logic [1:0]                ramstate
);

  arb_state_t state;
  logic       rr_ptr;
  logic       ifair;
  logic       gsel;

  logic       dreq;
  logic       ireq;
  logic       access;
  logic       pick;

  assign dreq   = dramREN | dramWEN;
  assign ireq   = |iREN;
  assign access = (ramstate == ACCESS);
  // Core at the pointer if it is asking, otherwise the other one.
  assign pick   = iREN[rr_ptr] ? rr_ptr : ~rr_ptr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      ifair  <= 1'b0;
      gsel   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Data has priority unless it was served last and a fetch waits.
          if (dreq && !(ifair && ireq)) begin
            state <= DATA;
          end else if (ireq) begin
            state <= INST;
            gsel  <= pick;
          end
        end
        DATA: begin
          // Hold the grant for the whole block; release only when the
          // controller drops its request.
          if (!dreq) begin
            state <= IDLE;
            ifair <= 1'b1;
          end
        end
        INST: begin
          if (access) begin
            state  <= IDLE;
            rr_ptr <= ~gsel;
            ifair  <= 1'b0;
          end else if (!iREN[gsel]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ramwait  = 1'b1;
    dramload = '0;
    iwait    = '1;
    iload    = '0;
    case (state)
      DATA: begin
        // Write wins when both enables are set.
        ramWEN   = dramWEN;
        ramREN   = dramREN & ~dramWEN;
        ramaddr  = dramaddr;
        ramstore = dramstore;
        dramload = ramload;
        ramwait  = ~access;
      end
      INST: begin
        ramREN      = 1'b1;
        ramaddr     = iaddr[gsel];
        iload[gsel] = ramload;
        iwait[gsel] = ~access;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic             CLK;
  logic             RST;
  logic             dramREN, dramWEN;
  logic [31:0]      dramaddr, dramstore, dramload;
  logic             ramwait;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  ram_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .RST(RST),
    .dramREN(dramREN), .dramWEN(dramWEN), .dramaddr(dramaddr),
    .dramstore(dramstore), .dramload(dramload), .ramwait(ramwait),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected completions: src 0 = data bus, 1 = core0, 2 = core1.
  typedef struct {
    int          src;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_done(input int src, input logic [31:0] data);
    exp_t e;
    e.src  = src;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic complete(input int src, input logic [31:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_completion: got source %0d data %h, expected none", src, d);
    end else begin
      e = exp_q.pop_front();
      chk("completion_source", 32'(src), 32'(e.src));
      chk("completion_data", d, e.data);
    end
  endtask

  // Monitor: any completion the DUT presents is matched against the queue.
  always @(negedge CLK) begin
    if (ramwait === 1'b0) complete(0, dramload);
    for (int i = 0; i < 2; i++)
      if (iwait[i] === 1'b0) complete(i + 1, iload[i]);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dramREN = 0; dramWEN = 0; dramaddr = 0; dramstore = 0;
    iREN = 0; iaddr = '0; ramload = 0; ramstate = FREE;
  endtask

  task automatic randomize_inputs();
    dramREN   = 1'($urandom);
    dramWEN   = 1'($urandom);
    dramaddr  = $urandom;
    dramstore = $urandom;
    iREN      = 2'($urandom);
    iaddr[0]  = $urandom;
    iaddr[1]  = $urandom;
    ramload   = $urandom;
    ramstate  = 2'($urandom);
  endtask

  initial begin
    // 1. Reset under random inputs.
    RST = 1;
    randomize_inputs();
    tick();
    randomize_inputs();
    #1;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramwait", 32'(ramwait), 32'd1);
    chk("rst_iwait", 32'(iwait), 32'd3);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_iload", iload[0] | iload[1], 32'd0);
    chk("rst_dramload", dramload, 32'd0);
    tick();
    RST = 0;
    clear_inputs();
    tick();

    // 2. Single fetch by core0, ACCESS two cycles after the grant.
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY;
    #1;
    chk("t2_idle_ramREN", 32'(ramREN), 32'd0);
    tick();
    #1;
    chk("t2_grant_ramREN", 32'(ramREN), 32'd1);
    chk("t2_grant_ramaddr", ramaddr, 32'h40);
    chk("t2_grant_iwait", 32'(iwait), 32'd3);
    tick();
    #1;
    chk("t2_busy_iwait", 32'(iwait), 32'd3);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    expect_done(1, 32'hDEADBEEF);
    tick();
    iREN = 0; ramstate = FREE;
    #1;
    chk("t2_after_iwait", 32'(iwait), 32'd3);
    chk("t2_after_iload", iload[0], 32'd0);

    // 3. Both cores fetch, RAM always ACCESS; pointer is now at core1.
    iREN = 2'b11; iaddr[0] = 32'h200; iaddr[1] = 32'h300; ramstate = ACCESS;
    tick();
    ramload = 32'hA1; expect_done(2, 32'hA1);
    #1;
    chk("t3_g1_ramaddr", ramaddr, 32'h300);
    tick();
    #1;
    chk("t3_idle1_ramREN", 32'(ramREN), 32'd0);
    tick();
    ramload = 32'hA2; expect_done(1, 32'hA2);
    #1;
    chk("t3_g2_ramaddr", ramaddr, 32'h200);
    tick();
    #1;
    chk("t3_idle2_ramREN", 32'(ramREN), 32'd0);
    tick();
    ramload = 32'hA3; expect_done(2, 32'hA3);
    #1;
    chk("t3_g3_ramaddr", ramaddr, 32'h300);
    tick();
    iREN = 0; ramstate = FREE;

    // 4. Two-word write block with core1 fetch pending.
    dramWEN = 1; dramaddr = 32'h100; dramstore = 32'h5555; iREN = 2'b10;
    iaddr[1] = 32'h400; ramstate = BUSY;
    tick();
    ramstate = ACCESS; ramload = 32'h11; expect_done(0, 32'h11);
    #1;
    chk("t4_w0_ramWEN", 32'(ramWEN), 32'd1);
    chk("t4_w0_ramREN", 32'(ramREN), 32'd0);
    chk("t4_w0_ramaddr", ramaddr, 32'h100);
    chk("t4_w0_ramstore", ramstore, 32'h5555);
    tick();
    dramaddr = 32'h104; dramstore = 32'h6666; ramload = 32'h22;
    expect_done(0, 32'h22);
    #1;
    chk("t4_w1_ramWEN", 32'(ramWEN), 32'd1);
    chk("t4_w1_ramaddr", ramaddr, 32'h104);
    chk("t4_w1_ramstore", ramstore, 32'h6666);
    tick();
    dramWEN = 0; ramstate = FREE;
    #1;
    chk("t4_release_ramREN", 32'(ramREN), 32'd0);
    tick();
    // New data request arrives while core1 waits: fairness gives core1 the RAM.
    dramREN = 1; dramaddr = 32'h108;
    #1;
    chk("t4_idle_ramREN", 32'(ramREN), 32'd0);
    tick();
    ramstate = ACCESS; ramload = 32'h77; expect_done(2, 32'h77);
    #1;
    chk("t4_fair_ramaddr", ramaddr, 32'h400);
    chk("t4_fair_ramWEN", 32'(ramWEN), 32'd0);
    tick();
    iREN = 0; ramstate = BUSY;
    #1;
    chk("t4_idle2_ramREN", 32'(ramREN), 32'd0);

    // 6. DATA read with ERROR for 3 cycles, then ACCESS.
    tick();
    ramstate = ERROR;
    #1;
    chk("t6_read_ramREN", 32'(ramREN), 32'd1);
    chk("t6_read_ramaddr", ramaddr, 32'h108);
    chk("t6_err0_ramwait", 32'(ramwait), 32'd1);
    tick();
    #1;
    chk("t6_err1_ramwait", 32'(ramwait), 32'd1);
    tick();
    #1;
    chk("t6_err2_ramwait", 32'(ramwait), 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'hCAFEF00D; expect_done(0, 32'hCAFEF00D);
    tick();
    dramREN = 0; ramstate = FREE;
    tick();

    // 5. Read and write both requested: write wins.
    dramREN = 1; dramWEN = 1; dramaddr = 32'h500; dramstore = 32'h9; ramstate = BUSY;
    tick();
    ramstate = ACCESS; ramload = 32'h12; expect_done(0, 32'h12);
    #1;
    chk("t5_ramWEN", 32'(ramWEN), 32'd1);
    chk("t5_ramREN", 32'(ramREN), 32'd0);
    chk("t5_ramaddr", ramaddr, 32'h500);
    tick();
    dramREN = 0; dramWEN = 0; ramstate = FREE;
    tick();

    // 6b. Reset in the middle of a fetch abandons it.
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY;
    tick();
    #1;
    chk("t6b_inst_ramREN", 32'(ramREN), 32'd1);
    RST = 1;
    tick();
    ramstate = ACCESS;
    #1;
    chk("t6b_rst_ramREN", 32'(ramREN), 32'd0);
    chk("t6b_rst_iwait", 32'(iwait), 32'd3);
    RST = 0; iREN = 0;
    tick();
    tick();

    chk("pending_completions", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
